// File: rtl/branch_redirect_unit_pkg.sv
// Shared branch condition encoding and resolver state type; also consumed by the decoder.
package branch_redirect_unit_pkg;

    // opCond[3] inverts, opCond[2] compares against zero, opCond[1:0] selects the flag
    localparam logic [3:0] COND_F    = 4'b0000;
    localparam logic [3:0] COND_EQ   = 4'b0001;
    localparam logic [3:0] COND_LT   = 4'b0010;
    localparam logic [3:0] COND_LTE  = 4'b0011;
    localparam logic [3:0] COND_EQZ  = 4'b0101;
    localparam logic [3:0] COND_LTZ  = 4'b0110;
    localparam logic [3:0] COND_LTEZ = 4'b0111;
    localparam logic [3:0] COND_T    = 4'b1000;
    localparam logic [3:0] COND_NE   = 4'b1001;
    localparam logic [3:0] COND_GTE  = 4'b1010;
    localparam logic [3:0] COND_GT   = 4'b1011;
    localparam logic [3:0] COND_NEZ  = 4'b1101;
    localparam logic [3:0] COND_GTEZ = 4'b1110;
    localparam logic [3:0] COND_GTZ  = 4'b1111;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_EQ   = 2'b01;
    localparam logic [1:0] SEL_LT   = 2'b10;
    localparam logic [1:0] SEL_LTE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } brs_state_t;

    function automatic logic cond_uses_zero(input logic [3:0] op_cond);
        return op_cond[2];
    endfunction

endpackage

// File: rtl/branch_redirect_unit_cond_eval.sv
// Combinational branch condition evaluator working from the A-B difference.
module branch_redirect_unit_cond_eval
    import branch_redirect_unit_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic [3:0]       i_op_cond,
    input  logic [DBITS-1:0] i_diff,
    output logic             o_taken
);

    logic w_eq;
    logic w_lt;
    logic w_cond;

    // Sign bit only: signed overflow is intentionally not corrected
    assign w_eq = (i_diff == '0);
    assign w_lt = i_diff[DBITS-1];

    always_comb begin
        w_cond = 1'b0;
        case (i_op_cond[1:0])
            SEL_NONE: w_cond = 1'b0;
            SEL_EQ:   w_cond = w_eq;
            SEL_LT:   w_cond = w_lt;
            SEL_LTE:  w_cond = w_eq | w_lt;
            default:  w_cond = 1'b0;
        endcase
    end

    assign o_taken = i_op_cond[3] ? ~w_cond : w_cond;

endmodule

// File: rtl/branch_redirect_unit.sv
// Execute-stage branch resolver: registers the compare difference, evaluates it,
// and drives a redirect/flush handshake to fetch on taken branches.
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int DBITS    = 32,
    parameter int PCBITS   = 32,
    parameter int IMMBITS  = 16,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_opCond,
    input  logic [DBITS-1:0]    in_a,
    input  logic [DBITS-1:0]    in_b,
    input  logic [PCBITS-1:0]   in_pc,
    input  logic [IMMBITS-1:0]  in_imm,
    input  logic                kill,
    output logic                res_valid,
    output logic                res_taken,
    output logic                redir_valid,
    input  logic                redir_ready,
    output logic [PCBITS-1:0]   redir_pc,
    output logic                flush_younger,
    output logic [CNT_BITS-1:0] branch_count,
    output logic [CNT_BITS-1:0] taken_count
);

    brs_state_t          r_state;
    brs_state_t          w_state_next;
    logic [DBITS-1:0]    r_diff;
    logic [3:0]          r_op_cond;
    logic [PCBITS-1:0]   r_target;
    logic                r_res_valid;
    logic                r_res_taken;
    logic                r_redir_valid;
    logic [PCBITS-1:0]   r_redir_pc;
    logic [CNT_BITS-1:0] r_branch_count;
    logic [CNT_BITS-1:0] r_taken_count;

    logic                w_accept;
    logic                w_resolve;
    logic                w_taken;
    logic [DBITS-1:0]    w_b_eff;
    logic [DBITS-1:0]    w_diff;
    logic [PCBITS-1:0]   w_imm_ext;
    logic [PCBITS-1:0]   w_target;

    assign w_b_eff   = cond_uses_zero(in_opCond) ? '0 : in_b;
    assign w_diff    = in_a - w_b_eff;
    assign w_imm_ext = {{(PCBITS-IMMBITS){in_imm[IMMBITS-1]}}, in_imm};
    assign w_target  = in_pc + PCBITS'(4) + (w_imm_ext << 2);

    branch_redirect_unit_cond_eval #(
        .DBITS (DBITS)
    ) u_cond_eval (
        .i_op_cond (r_op_cond),
        .i_diff    (r_diff),
        .o_taken   (w_taken)
    );

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        w_resolve    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !kill) begin
                    w_accept     = 1'b1;
                    w_state_next = EVAL;
                end
            end
            EVAL: begin
                if (kill) begin
                    w_state_next = IDLE;
                end else begin
                    w_resolve    = 1'b1;
                    w_state_next = w_taken ? REDIRECT : IDLE;
                end
            end
            REDIRECT: begin
                if (kill || redir_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_diff         <= '0;
            r_op_cond      <= '0;
            r_target       <= '0;
            r_res_valid    <= 1'b0;
            r_res_taken    <= 1'b0;
            r_redir_valid  <= 1'b0;
            r_redir_pc     <= '0;
            r_branch_count <= '0;
            r_taken_count  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_res_valid <= w_resolve;
            if (w_accept) begin
                r_diff    <= w_diff;
                r_op_cond <= in_opCond;
                r_target  <= w_target;
            end
            if (w_resolve) begin
                r_res_taken <= w_taken;
                if (r_branch_count != {CNT_BITS{1'b1}}) begin
                    r_branch_count <= r_branch_count + CNT_BITS'(1);
                end
                if (w_taken) begin
                    r_redir_valid <= 1'b1;
                    r_redir_pc    <= r_target;
                    if (r_taken_count != {CNT_BITS{1'b1}}) begin
                        r_taken_count <= r_taken_count + CNT_BITS'(1);
                    end
                end
            end
            // A kill withdraws the request even if fetch accepts in the same cycle
            if (r_state == REDIRECT && (kill || redir_ready)) begin
                r_redir_valid <= 1'b0;
            end
        end
    end

    assign res_valid     = r_res_valid;
    assign res_taken     = r_res_taken;
    assign redir_valid   = r_redir_valid;
    assign redir_pc      = r_redir_pc;
    assign flush_younger = r_redir_valid & redir_ready & ~kill;
    assign branch_count  = r_branch_count;
    assign taken_count   = r_taken_count;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed and randomized checks of branch_redirect_unit against a behavioural model.
module tb_branch_redirect_unit;
    import branch_redirect_unit_pkg::*;

    localparam int DBITS    = 32;
    localparam int PCBITS   = 32;
    localparam int IMMBITS  = 16;
    localparam int CNT_BITS = 4;
    localparam int CMAX     = (1 << CNT_BITS) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          in_opCond;
    logic [DBITS-1:0]    in_a;
    logic [DBITS-1:0]    in_b;
    logic [PCBITS-1:0]   in_pc;
    logic [IMMBITS-1:0]  in_imm;
    logic                kill;
    logic                res_valid;
    logic                res_taken;
    logic                redir_valid;
    logic                redir_ready;
    logic [PCBITS-1:0]   redir_pc;
    logic                flush_younger;
    logic [CNT_BITS-1:0] branch_count;
    logic [CNT_BITS-1:0] taken_count;

    int n_pass   = 0;
    int n_checks = 0;
    int m_branch = 0;
    int m_taken  = 0;

    always #5 clk = ~clk;

    branch_redirect_unit #(
        .DBITS    (DBITS),
        .PCBITS   (PCBITS),
        .IMMBITS  (IMMBITS),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opCond     (in_opCond),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_pc         (in_pc),
        .in_imm        (in_imm),
        .kill          (kill),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .redir_valid   (redir_valid),
        .redir_ready   (redir_ready),
        .redir_pc      (redir_pc),
        .flush_younger (flush_younger),
        .branch_count  (branch_count),
        .taken_count   (taken_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed view of A minus (B or zero), compared per named condition
    function automatic logic ref_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sd;
        sd = $signed(a - ((op == COND_EQZ || op == COND_LTZ || op == COND_LTEZ ||
                           op == COND_NEZ || op == COND_GTEZ || op == COND_GTZ) ? 32'd0 : b));
        case (op)
            COND_EQ,  COND_EQZ:  return sd == 0;
            COND_LT,  COND_LTZ:  return sd < 0;
            COND_LTE, COND_LTEZ: return sd <= 0;
            COND_NE,  COND_NEZ:  return sd != 0;
            COND_GTE, COND_GTEZ: return sd >= 0;
            COND_GT,  COND_GTZ:  return sd > 0;
            COND_T, 4'b1100:     return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
        int off;
        off = 4 + 4 * int'($signed(imm));
        return pc + 32'(off);
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Full branch: accept, EVAL, resolve, and (if taken) redirect held for 'hold' cycles
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [15:0] imm, input int hold);
        logic        exp_t;
        logic [31:0] exp_pc;
        exp_t  = ref_taken(op, a, b);
        exp_pc = ref_target(pc, imm);
        in_valid = 1'b1; in_opCond = op; in_a = a; in_b = b; in_pc = pc; in_imm = imm;
        check("in_ready_idle", in_ready, 1);
        tick();
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_pc = $urandom; in_imm = 16'($urandom);
        check("in_ready_eval", in_ready, 0);
        check("res_valid_eval", res_valid, 0);
        m_branch = sat_inc(m_branch);
        if (exp_t) m_taken = sat_inc(m_taken);
        tick();
        check("res_valid", res_valid, 1);
        check("res_taken", res_taken, exp_t);
        check("branch_count", branch_count, m_branch);
        check("taken_count", taken_count, m_taken);
        check("redir_valid", redir_valid, exp_t);
        check("in_ready_after", in_ready, !exp_t);
        if (exp_t) begin
            check("redir_pc", redir_pc, exp_pc);
            for (int i = 0; i < hold; i++) begin
                tick();
                check("redir_valid_hold", redir_valid, 1);
                check("redir_pc_hold", redir_pc, exp_pc);
                check("flush_hold", flush_younger, 0);
                check("res_valid_pulse", res_valid, 0);
            end
            redir_ready = 1'b1;
            #1;
            check("flush_younger", flush_younger, 1);
            tick();
            redir_ready = 1'b0;
            #1;
            check("redir_valid_done", redir_valid, 0);
            check("in_ready_done", in_ready, 1);
        end
        $display("txn op=%b a=%h b=%h pc=%h imm=%h taken=%0d target=%h counts=%0d/%0d",
                 op, a, b, pc, imm, exp_t, exp_pc, m_branch, m_taken);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_opCond = '0; in_a = '0; in_b = '0;
        in_pc = '0; in_imm = '0; kill = 1'b0; redir_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_redir_valid", redir_valid, 0);
        check("rst_redir_pc", redir_pc, 0);
        check("rst_counts", {branch_count, taken_count}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Directed cases
        issue(COND_EQ, 32'd5, 32'd5, 32'h100, 16'd3, 3);
        issue(COND_GTE, 32'h3, 32'h7, 32'h200, 16'd8, 0);
        issue(COND_LTEZ, 32'h0, 32'hDEADBEEF, 32'h300, 16'd1, 0);
        issue(COND_GTZ, 32'h1, 32'h0, 32'h400, 16'hFFF0, 1);
        issue(COND_GTEZ, 32'h80000000, 32'h5, 32'h500, 16'd2, 0);
        issue(COND_T, 32'h0, 32'h0, 32'h0, 16'hFFFF, 0);
        issue(COND_LT, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h1000, 16'h7FFF, 2);

        // Kill in IDLE blocks acceptance
        in_valid = 1'b1; in_opCond = COND_T; kill = 1'b1;
        tick();
        in_valid = 1'b0; kill = 1'b0;
        check("kill_idle_ready", in_ready, 1);
        tick();
        check("kill_idle_res", res_valid, 0);

        // Kill in EVAL: no result, no count
        in_valid = 1'b1; in_opCond = COND_EQ; in_a = 32'd9; in_b = 32'd9;
        tick();
        in_valid = 1'b0; kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_eval_res", res_valid, 0);
        check("kill_eval_redir", redir_valid, 0);
        check("kill_eval_bcnt", branch_count, m_branch);
        check("kill_eval_tcnt", taken_count, m_taken);
        check("kill_eval_ready", in_ready, 1);

        // Kill together with redir_ready in REDIRECT
        in_valid = 1'b1; in_opCond = COND_T; in_pc = 32'h40; in_imm = 16'd4;
        tick();
        in_valid = 1'b0;
        m_branch = sat_inc(m_branch); m_taken = sat_inc(m_taken);
        tick();
        check("kr_redir_valid", redir_valid, 1);
        kill = 1'b1; redir_ready = 1'b1;
        #1;
        check("kr_flush", flush_younger, 0);
        tick();
        kill = 1'b0; redir_ready = 1'b0;
        check("kr_redir_drop", redir_valid, 0);
        check("kr_ready", in_ready, 1);
        check("kr_bcnt", branch_count, m_branch);
        $display("txn kill+redir_ready in REDIRECT counts=%0d/%0d", m_branch, m_taken);

        // Randomized branches against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra, rb;
            logic [3:0]  rop;
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            issue(rop, ra, rb, $urandom & 32'hFFFFFFFC, 16'($urandom), $urandom_range(0, 2));
        end

        // Asynchronous reset while a redirect is pending
        in_valid = 1'b1; in_opCond = COND_NE; in_a = 32'd1; in_b = 32'd2;
        tick();
        in_valid = 1'b0;
        tick();
        check("ar_redir_valid", redir_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_redir_drop", redir_valid, 0);
        check("ar_counts", {branch_count, taken_count}, 0);
        check("ar_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        m_branch = 0; m_taken = 0;
        tick();
        $display("txn async reset in REDIRECT");

        // Saturation: never-taken F, then 17 always-taken T
        issue(COND_F, $urandom, $urandom, 32'h80, 16'd1, 0);
        for (int n = 0; n < 17; n++) begin
            issue(COND_T, $urandom, $urandom, 32'h800, 16'($urandom), 0);
        end
        check("sat_branch", branch_count, CMAX);
        check("sat_taken", taken_count, CMAX);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
